// File: rtl/redmule_boot_ctrl.sv
// Boot/reset sequencer for the RedMulE top levels: drives a double core reset,
// a settle window and fetch enable, then watches for end-of-computation with
// an optional watchdog. All DUT-facing outputs come straight from flops.
module redmule_boot_ctrl #(
    parameter int unsigned RST1_CYCLES    = 20,
    parameter int unsigned REL_CYCLES     = 10,
    parameter int unsigned RST2_CYCLES    = 10,
    parameter int unsigned SETTLE_CYCLES  = 100,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    input  logic             eoc_i,
    input  logic [31:0]      exit_code_i,
    output logic             core_rst_no,
    output logic             fetch_enable_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [31:0]      exit_code_o,
    output logic [CNT_W-1:0] run_cycles_o
);

    localparam logic [2:0] RST1      = 3'd0;
    localparam logic [2:0] REL       = 3'd1;
    localparam logic [2:0] RST2      = 3'd2;
    localparam logic [2:0] SETTLE    = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;
    localparam logic [2:0] IDLE_DONE = 3'd5;
    localparam logic [2:0] TIMEOUT   = 3'd6;

    localparam logic [31:0] RST1_LAST   = 32'(RST1_CYCLES - 1);
    localparam logic [31:0] REL_LAST    = 32'(REL_CYCLES - 1);
    localparam logic [31:0] RST2_LAST   = 32'(RST2_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    generate
        if (RST1_CYCLES < 1)   begin : g_chk_rst1   $error("RST1_CYCLES must be >= 1");   end
        if (REL_CYCLES < 1)    begin : g_chk_rel    $error("REL_CYCLES must be >= 1");    end
        if (RST2_CYCLES < 1)   begin : g_chk_rst2   $error("RST2_CYCLES must be >= 1");   end
        if (SETTLE_CYCLES < 1) begin : g_chk_settle $error("SETTLE_CYCLES must be >= 1"); end
    endgenerate

    logic [2:0]  state;
    logic [31:0] phase;
    // The reset/restart edge counts as cycle -1, so the phase counter is
    // frozen for the first cycle after it; this makes RST1 span cycles 0..N-1.
    logic        hold;
    logic        wd_hit;

    // Watchdog fires on the last allowed RUN cycle (disabled when limit is 0).
    always_comb begin
        wd_hit = 1'b0;
        if (TIMEOUT_CYCLES != 0)
            wd_hit = (run_cycles_o == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Sequencer state, phase counter and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i) begin
            state          <= RST1;
            phase          <= '0;
            hold           <= 1'b1;
            core_rst_no    <= 1'b0;
            fetch_enable_o <= 1'b0;
            busy_o         <= 1'b1;
            done_o         <= 1'b0;
            timeout_o      <= 1'b0;
            exit_code_o    <= '0;
            run_cycles_o   <= '0;
        end else begin
            hold <= 1'b0;
            case (state)
                RST1: if (!hold) begin
                    if (phase == RST1_LAST) begin
                        state       <= REL;
                        phase       <= '0;
                        core_rst_no <= 1'b1;
                    end else begin
                        phase <= phase + 32'd1;
                    end
                end
                REL: begin
                    if (phase == REL_LAST) begin
                        state       <= RST2;
                        phase       <= '0;
                        core_rst_no <= 1'b0;
                    end else begin
                        phase <= phase + 32'd1;
                    end
                end
                RST2: begin
                    if (phase == RST2_LAST) begin
                        state       <= SETTLE;
                        phase       <= '0;
                        core_rst_no <= 1'b1;
                    end else begin
                        phase <= phase + 32'd1;
                    end
                end
                SETTLE: begin
                    if (phase == SETTLE_LAST) begin
                        state          <= RUN;
                        phase          <= '0;
                        fetch_enable_o <= 1'b1;
                    end else begin
                        phase <= phase + 32'd1;
                    end
                end
                RUN: begin
                    if (run_cycles_o != '1)
                        run_cycles_o <= run_cycles_o + 1'b1;
                    if (eoc_i) begin
                        state          <= IDLE_DONE;
                        done_o         <= 1'b1;
                        exit_code_o    <= exit_code_i;
                        fetch_enable_o <= 1'b0;
                        busy_o         <= 1'b0;
                    end else if (wd_hit) begin
                        state          <= TIMEOUT;
                        timeout_o      <= 1'b1;
                        fetch_enable_o <= 1'b0;
                        core_rst_no    <= 1'b0;
                        busy_o         <= 1'b0;
                    end
                end
                IDLE_DONE, TIMEOUT: begin
                    state <= state;
                end
                default: begin
                    state <= RST1;
                    phase <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redmule_boot_ctrl.sv
// Directed bench for redmule_boot_ctrl: one instance with the watchdog off,
// one with TIMEOUT_CYCLES = 50, both driven by the same stimulus.
module tb_redmule_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        eoc = 1'b0;
    logic [31:0] exit_code = '0;

    logic        a_core, a_fe, a_busy, a_done, a_to;
    logic [31:0] a_exit, a_run;
    logic        b_core, b_fe, b_busy, b_done, b_to;
    logic [31:0] b_exit, b_run;

    int errors = 0;
    int checks = 0;
    int cyc = -1;

    always #5 clk = ~clk;

    redmule_boot_ctrl dut0 (
        .clk_i(clk), .rst_i(rst), .restart_i(restart), .eoc_i(eoc), .exit_code_i(exit_code),
        .core_rst_no(a_core), .fetch_enable_o(a_fe), .busy_o(a_busy), .done_o(a_done),
        .timeout_o(a_to), .exit_code_o(a_exit), .run_cycles_o(a_run)
    );

    redmule_boot_ctrl #(.TIMEOUT_CYCLES(50)) dut1 (
        .clk_i(clk), .rst_i(rst), .restart_i(restart), .eoc_i(eoc), .exit_code_i(exit_code),
        .core_rst_no(b_core), .fetch_enable_o(b_fe), .busy_o(b_busy), .done_o(b_done),
        .timeout_o(b_to), .exit_code_o(b_exit), .run_cycles_o(b_run)
    );

    // Advance one edge; afterwards cyc is the index of the edge just passed.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        cyc = -1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_core !== 1'b0) begin errors++; $display("FAIL reset_core: got %b want 0", a_core); end
        checks++; if (a_fe !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b want 0", a_fe); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
        checks++; if (a_to !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", a_to); end
        checks++; if (a_exit !== 32'h0) begin errors++; $display("FAIL reset_exit: got %h want 0", a_exit); end
        checks++; if (a_run !== 32'h0) begin errors++; $display("FAIL reset_run: got %0d want 0", a_run); end
        checks++; if (b_busy !== 1'b1 || b_core !== 1'b0) begin errors++; $display("FAIL reset_dut1: busy=%b core=%b want 1/0", b_busy, b_core); end
    endtask

    task automatic test_default_boot();
        logic ec, ef;
        do_reset();
        for (int c = 0; c <= 150; c++) begin
            tick();
            ec = ((cyc >= 20) && (cyc < 30)) || (cyc >= 40);
            ef = (cyc >= 140);
            checks++; if (a_core !== ec) begin errors++; $display("FAIL boot_core@%0d: got %b want %b", cyc, a_core, ec); end
            checks++; if (a_fe !== ef) begin errors++; $display("FAIL boot_fe@%0d: got %b want %b", cyc, a_fe, ef); end
            checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL boot_busy@%0d: got %b want 1", cyc, a_busy); end
        end
    endtask

    // Continues from the default boot timeline.
    task automatic test_normal_eoc();
        go_to(200);
        eoc = 1'b1; exit_code = 32'h0000_0000;
        tick();
        eoc = 1'b0;
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL eoc_done: got %b want 1", a_done); end
        checks++; if (a_fe !== 1'b0) begin errors++; $display("FAIL eoc_fe: got %b want 0", a_fe); end
        checks++; if (a_exit !== 32'h0) begin errors++; $display("FAIL eoc_exit: got %h want 0", a_exit); end
        checks++; if (a_run !== 32'd61) begin errors++; $display("FAIL eoc_run: got %0d want 61", a_run); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL eoc_busy: got %b want 0", a_busy); end
        checks++; if (a_core !== 1'b1) begin errors++; $display("FAIL eoc_core: got %b want 1", a_core); end
        go_to(250);
        eoc = 1'b1; exit_code = 32'h1234_5678;
        tick();
        eoc = 1'b0;
        tick();
        checks++; if (a_exit !== 32'h0) begin errors++; $display("FAIL eoc2_exit: got %h want 0", a_exit); end
        checks++; if (a_run !== 32'd61) begin errors++; $display("FAIL eoc2_run: got %0d want 61", a_run); end
        checks++; if (a_done !== 1'b1 || a_fe !== 1'b0) begin errors++; $display("FAIL eoc2_flags: done=%b fe=%b want 1/0", a_done, a_fe); end
    endtask

    task automatic test_watchdog();
        do_reset();
        go_to(189);
        checks++; if (b_to !== 1'b0 || b_run !== 32'd49) begin errors++; $display("FAIL wd_pre: to=%b run=%0d want 0/49", b_to, b_run); end
        tick();
        checks++; if (b_to !== 1'b1) begin errors++; $display("FAIL wd_to: got %b want 1", b_to); end
        checks++; if (b_core !== 1'b0) begin errors++; $display("FAIL wd_core: got %b want 0", b_core); end
        checks++; if (b_fe !== 1'b0) begin errors++; $display("FAIL wd_fe: got %b want 0", b_fe); end
        checks++; if (b_run !== 32'd50) begin errors++; $display("FAIL wd_run: got %0d want 50", b_run); end
        checks++; if (b_busy !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL wd_busy_done: busy=%b done=%b want 0/0", b_busy, b_done); end
        checks++; if (a_to !== 1'b0 || a_fe !== 1'b1) begin errors++; $display("FAIL wd_disabled: to=%b fe=%b want 0/1", a_to, a_fe); end
        repeat (5) tick();
        checks++; if (b_run !== 32'd50 || b_to !== 1'b1) begin errors++; $display("FAIL wd_hold: run=%0d to=%b want 50/1", b_run, b_to); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        go_to(189);
        eoc = 1'b1; exit_code = 32'hDEAD_BEEF;
        tick();
        eoc = 1'b0;
        checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL sim_done: got %b want 1", b_done); end
        checks++; if (b_exit !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sim_exit: got %h want deadbeef", b_exit); end
        checks++; if (b_to !== 1'b0) begin errors++; $display("FAIL sim_to: got %b want 0", b_to); end
        checks++; if (b_core !== 1'b1 || b_fe !== 1'b0) begin errors++; $display("FAIL sim_outs: core=%b fe=%b want 1/0", b_core, b_fe); end
        checks++; if (b_run !== 32'd50) begin errors++; $display("FAIL sim_run: got %0d want 50", b_run); end
    endtask

    task automatic test_restart();
        int e;
        logic ec, ef;
        do_reset();
        go_to(99);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        e = cyc;  // restart edge = relative cycle -1
        checks++; if (a_core !== 1'b0 || a_fe !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL rs_entry: core=%b fe=%b busy=%b want 0/0/1", a_core, a_fe, a_busy); end
        for (int c = 0; c <= 145; c++) begin
            tick();
            ec = ((cyc - e - 1 >= 20) && (cyc - e - 1 < 30)) || (cyc - e - 1 >= 40);
            ef = (cyc - e - 1 >= 140);
            checks++; if (a_core !== ec) begin errors++; $display("FAIL rs_core@%0d: got %b want %b", cyc, a_core, ec); end
            checks++; if (a_fe !== ef) begin errors++; $display("FAIL rs_fe@%0d: got %b want %b", cyc, a_fe, ef); end
        end
        go_to(250);
        eoc = 1'b1; exit_code = 32'hA5A5_0001;
        tick();
        eoc = 1'b0;
        checks++; if (a_done !== 1'b1 || a_exit !== 32'hA5A5_0001) begin errors++; $display("FAIL rs_eoc: done=%b exit=%h want 1/a5a50001", a_done, a_exit); end
        checks++; if (a_run !== 32'd10) begin errors++; $display("FAIL rs_run: got %0d want 10", a_run); end
        go_to(255);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if (a_done !== 1'b0 || a_to !== 1'b0) begin errors++; $display("FAIL rs_idle_flags: done=%b to=%b want 0/0", a_done, a_to); end
        checks++; if (a_exit !== 32'h0 || a_run !== 32'h0) begin errors++; $display("FAIL rs_idle_regs: exit=%h run=%0d want 0/0", a_exit, a_run); end
        checks++; if (a_core !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL rs_idle_outs: core=%b busy=%b want 0/1", a_core, a_busy); end
        go_to(276);
        checks++; if (a_core !== 1'b0) begin errors++; $display("FAIL rs_rerun_low: got %b want 0", a_core); end
        tick();
        checks++; if (a_core !== 1'b1) begin errors++; $display("FAIL rs_rerun_rise: got %b want 1", a_core); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        go_to(160);
        checks++; if (a_run !== 32'd20 || a_fe !== 1'b1) begin errors++; $display("FAIL mid_pre: run=%0d fe=%b want 20/1", a_run, a_fe); end
        rst = 1'b1; restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if (a_run !== 32'h0 || a_fe !== 1'b0 || a_core !== 1'b0) begin errors++; $display("FAIL mid_reset: run=%0d fe=%b core=%b want 0/0/0", a_run, a_fe, a_core); end
        checks++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL mid_flags: busy=%b done=%b want 1/0", a_busy, a_done); end
        rst = 1'b0;
        cyc = -1;
    endtask

    task automatic test_early_eoc();
        do_reset();
        eoc = 1'b1; exit_code = 32'h0BAD_F00D;
        go_to(139);
        checks++; if (a_done !== 1'b0 || a_exit !== 32'h0) begin errors++; $display("FAIL early_ignored: done=%b exit=%h want 0/0", a_done, a_exit); end
        tick();
        checks++; if (a_fe !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL early_run: fe=%b done=%b want 1/0", a_fe, a_done); end
        tick();
        eoc = 1'b0;
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL early_done: got %b want 1", a_done); end
        checks++; if (a_run !== 32'd1) begin errors++; $display("FAIL early_run_cnt: got %0d want 1", a_run); end
        checks++; if (a_exit !== 32'h0BAD_F00D || a_fe !== 1'b0) begin errors++; $display("FAIL early_exit: exit=%h fe=%b want 0badf00d/0", a_exit, a_fe); end
    endtask

    initial begin
        test_reset();
        test_default_boot();
        test_normal_eoc();
        test_watchdog();
        test_simultaneous();
        test_restart();
        test_reset_mid_run();
        test_early_eoc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
